// File: rtl/riscv_mainfsm.sv
// riscv_mainfsm: multicycle RISC-V main controller.
// Walks each instruction through FETCH/DECODE/execute/memory/writeback
// states and drives the datapath enables and mux selects. Outputs are
// Moore (decoded from state) except PCWrite (needs Zero), ImmSrc (pure
// opcode decode) and illegal_op (opcode check in DECODE).
// Optional feature macro: RISCV_MAINFSM_BNE_EN -- when defined, the branch
// state honours funct3[0] so bne is taken on Zero=0; otherwise every
// branch opcode behaves as beq.
module riscv_mainfsm (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       Zero,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic       RegWrite,
    output logic [1:0] ImmSrc,
    output logic [3:0] state_o,
    output logic       illegal_op
);

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECUTER = 4'd6;
    localparam logic [3:0] S_ALUWB    = 4'd7;
    localparam logic [3:0] S_EXECUTEI = 4'd8;
    localparam logic [3:0] S_JAL      = 4'd9;
    localparam logic [3:0] S_BEQ      = 4'd10;

    localparam logic [6:0] OP_LW     = 7'b0000011;
    localparam logic [6:0] OP_SW     = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    logic [3:0] r_state;
    logic [3:0] w_next_state;
    logic       w_pc_update;
    logic       w_branch;
    logic       w_take;
    logic       w_op_known;

    assign w_op_known = (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
                        (op == OP_IALU) || (op == OP_JAL) || (op == OP_BRANCH);

`ifdef RISCV_MAINFSM_BNE_EN
    // funct3[0] flips the sense of the compare: beq (000) vs bne (001).
    assign w_take = Zero ^ funct3[0];
`else
    // Every branch is treated as beq; funct3 is not needed here.
    logic w_unused_funct3;
    assign w_unused_funct3 = ^funct3;
    assign w_take = Zero;
`endif

    assign state_o = r_state;
    assign PCWrite = w_pc_update | (w_branch & w_take);

    // State register; reset abandons any in-flight instruction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode; unused codes recover to FETCH.
    always_comb begin
        w_next_state = S_FETCH;
        case (r_state)
            S_FETCH:    w_next_state = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: w_next_state = S_MEMADR;
                    OP_RTYPE:     w_next_state = S_EXECUTER;
                    OP_IALU:      w_next_state = S_EXECUTEI;
                    OP_JAL:       w_next_state = S_JAL;
                    OP_BRANCH:    w_next_state = S_BEQ;
                    default:      w_next_state = S_FETCH;
                endcase
            end
            S_MEMADR:   w_next_state = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  w_next_state = S_MEMWB;
            S_MEMWB:    w_next_state = S_FETCH;
            S_MEMWRITE: w_next_state = S_FETCH;
            S_EXECUTER: w_next_state = S_ALUWB;
            S_EXECUTEI: w_next_state = S_ALUWB;
            S_JAL:      w_next_state = S_ALUWB;
            S_ALUWB:    w_next_state = S_FETCH;
            S_BEQ:      w_next_state = S_FETCH;
            default:    w_next_state = S_FETCH;
        endcase
    end

    // Moore output decode; anything not set for a state stays 0.
    always_comb begin
        AdrSrc      = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        ResultSrc   = 2'b00;
        ALUSrcA     = 2'b00;
        ALUSrcB     = 2'b00;
        ALUOp       = 2'b00;
        RegWrite    = 1'b0;
        w_pc_update = 1'b0;
        w_branch    = 1'b0;
        illegal_op  = 1'b0;
        case (r_state)
            S_FETCH: begin
                IRWrite     = 1'b1;
                ALUSrcB     = 2'b10;
                ResultSrc   = 2'b10;
                w_pc_update = 1'b1;
            end
            S_DECODE: begin
                ALUSrcA    = 2'b01;
                ALUSrcB    = 2'b01;
                illegal_op = ~w_op_known;
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
            end
            S_MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
            end
            S_EXECUTER: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b10;
            end
            S_EXECUTEI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ALUOp   = 2'b10;
            end
            S_ALUWB: begin
                RegWrite = 1'b1;
            end
            S_JAL: begin
                ALUSrcA     = 2'b01;
                ALUSrcB     = 2'b10;
                w_pc_update = 1'b1;
            end
            S_BEQ: begin
                ALUSrcA  = 2'b10;
                ALUOp    = 2'b01;
                w_branch = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Immediate format follows the opcode alone, independent of state.
    always_comb begin
        case (op)
            OP_SW:     ImmSrc = 2'b01;
            OP_BRANCH: ImmSrc = 2'b10;
            OP_JAL:    ImmSrc = 2'b11;
            default:   ImmSrc = 2'b00;
        endcase
    end

endmodule

// File: tb/tb_riscv_mainfsm.sv
// Directed bench for riscv_mainfsm: per-instruction state walks with
// hand-computed expected states and control values.
module tb_riscv_mainfsm;

    logic       clk;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       Zero;
    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic       RegWrite;
    logic [1:0] ImmSrc;
    logic [3:0] state_o;
    logic       illegal_op;

    int n_checks = 0;
    int n_fail   = 0;

    // expected state sequence for the current instruction
    logic [3:0] exp_q[$];

    // per-cycle capture of the last instruction walk
    logic [3:0] c_state [8];
    logic       c_pcw   [8];
    logic       c_memw  [8];
    logic       c_regw  [8];
    logic       c_adr   [8];
    logic       c_ir    [8];
    logic       c_ill   [8];
    logic [1:0] c_res   [8];
    logic [1:0] c_srca  [8];
    logic [1:0] c_srcb  [8];
    logic [1:0] c_aluop [8];
    logic [1:0] c_imm   [8];

    riscv_mainfsm dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct3     (funct3),
        .Zero       (Zero),
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ALUOp      (ALUOp),
        .RegWrite   (RegWrite),
        .ImmSrc     (ImmSrc),
        .state_o    (state_o),
        .illegal_op (illegal_op)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic capture(input int i);
        c_state[i] = state_o;   c_pcw[i]   = PCWrite;  c_memw[i] = MemWrite;
        c_regw[i]  = RegWrite;  c_adr[i]   = AdrSrc;   c_ir[i]   = IRWrite;
        c_ill[i]   = illegal_op; c_res[i]  = ResultSrc; c_srca[i] = ALUSrcA;
        c_srcb[i]  = ALUSrcB;   c_aluop[i] = ALUOp;    c_imm[i]  = ImmSrc;
    endtask

    // Driver: called in the low phase while in FETCH; drives the
    // instruction fields and walks n cycles, checking each state against
    // exp_q. Ends in the low phase of the last captured cycle.
    task automatic run_seq(input string name, input logic [6:0] op_v,
                           input logic [2:0] f3, input logic z, input int n);
        logic [3:0] e;
        op = op_v; funct3 = f3; Zero = z;
        for (int i = 0; i < n; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            capture(i);
            if (exp_q.size() == 0) begin
                e = 4'hf;
            end else begin
                e = exp_q.pop_front();
            end
            check_eq($sformatf("%s_state%0d", name, i), {28'd0, c_state[i]}, {28'd0, e});
        end
    endtask

    initial begin
        reset = 1'b1; op = 7'd0; funct3 = 3'd0; Zero = 1'b0;

        // values held during reset
        repeat (2) @(negedge clk);
        #1;
        check_eq("rst_state",    {28'd0, state_o},   32'd0);
        check_eq("rst_irwrite",  {31'd0, IRWrite},   32'd1);
        check_eq("rst_pcwrite",  {31'd0, PCWrite},   32'd1);
        check_eq("rst_alusrcb",  {30'd0, ALUSrcB},   32'd2);
        check_eq("rst_resultsrc",{30'd0, ResultSrc}, 32'd2);
        check_eq("rst_regwrite", {31'd0, RegWrite},  32'd0);
        check_eq("rst_memwrite", {31'd0, MemWrite},  32'd0);
        check_eq("rst_illegal",  {31'd0, illegal_op},32'd0);
        reset = 1'b0;

        // lw interrupted in MEMREAD by an asynchronous reset
        exp_q = '{4'd0, 4'd1, 4'd2, 4'd3};
        run_seq("lwpart", 7'b0000011, 3'b010, 1'b0, 4);
        check_eq("lwpart_adrsrc", {31'd0, c_adr[3]}, 32'd1);
        reset = 1'b1;
        #1;
        check_eq("midrst_state",    {28'd0, state_o},  32'd0);
        check_eq("midrst_irwrite",  {31'd0, IRWrite},  32'd1);
        check_eq("midrst_regwrite", {31'd0, RegWrite}, 32'd0);
        check_eq("midrst_memwrite", {31'd0, MemWrite}, 32'd0);
        check_eq("midrst_adrsrc",   {31'd0, AdrSrc},   32'd0);
        @(negedge clk);
        check_eq("midrst_hold", {28'd0, state_o}, 32'd0);
        reset = 1'b0;

        // lw: 0,1,2,3,4,0
        exp_q = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
        run_seq("lw", 7'b0000011, 3'b010, 1'b0, 6);
        for (int i = 0; i < 5; i++) begin
            check_eq($sformatf("lw_memwrite%0d", i), {31'd0, c_memw[i]}, 32'd0);
            check_eq($sformatf("lw_regwrite%0d", i), {31'd0, c_regw[i]}, (i == 4) ? 32'd1 : 32'd0);
        end
        check_eq("lw_resultsrc4", {30'd0, c_res[4]},  32'd1);
        check_eq("lw_immsrc",     {30'd0, c_imm[1]},  32'd0);
        check_eq("lw_fetch_ir",   {31'd0, c_ir[0]},   32'd1);
        check_eq("lw_fetch_pcw",  {31'd0, c_pcw[0]},  32'd1);
        check_eq("lw_decode_srca",{30'd0, c_srca[1]}, 32'd1);
        check_eq("lw_decode_srcb",{30'd0, c_srcb[1]}, 32'd1);
        check_eq("lw_memadr_srca",{30'd0, c_srca[2]}, 32'd2);
        check_eq("lw_decode_ir",  {31'd0, c_ir[1]},   32'd0);

        // sw: 0,1,2,5,0
        exp_q = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd0};
        run_seq("sw", 7'b0100011, 3'b010, 1'b0, 5);
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("sw_memwrite%0d", i), {31'd0, c_memw[i]}, (i == 3) ? 32'd1 : 32'd0);
            check_eq($sformatf("sw_regwrite%0d", i), {31'd0, c_regw[i]}, 32'd0);
        end
        check_eq("sw_adrsrc3", {31'd0, c_adr[3]}, 32'd1);
        check_eq("sw_adrsrc2", {31'd0, c_adr[2]}, 32'd0);
        check_eq("sw_immsrc",  {30'd0, c_imm[1]}, 32'd1);

        // R-type: 0,1,6,7,0 (Zero held high to catch stray branch enables)
        exp_q = '{4'd0, 4'd1, 4'd6, 4'd7, 4'd0};
        run_seq("rtype", 7'b0110011, 3'b000, 1'b1, 5);
        check_eq("rtype_aluop2", {30'd0, c_aluop[2]}, 32'd2);
        check_eq("rtype_srca2",  {30'd0, c_srca[2]},  32'd2);
        check_eq("rtype_srcb2",  {30'd0, c_srcb[2]},  32'd0);
        check_eq("rtype_regw2",  {31'd0, c_regw[2]},  32'd0);
        check_eq("rtype_regw3",  {31'd0, c_regw[3]},  32'd1);
        check_eq("rtype_res3",   {30'd0, c_res[3]},   32'd0);
        check_eq("rtype_pcw2",   {31'd0, c_pcw[2]},   32'd0);
        check_eq("rtype_pcw3",   {31'd0, c_pcw[3]},   32'd0);

        // I-ALU: 0,1,8,7,0
        exp_q = '{4'd0, 4'd1, 4'd8, 4'd7, 4'd0};
        run_seq("ialu", 7'b0010011, 3'b000, 1'b0, 5);
        check_eq("ialu_aluop2", {30'd0, c_aluop[2]}, 32'd2);
        check_eq("ialu_srcb2",  {30'd0, c_srcb[2]},  32'd1);
        check_eq("ialu_immsrc", {30'd0, c_imm[1]},   32'd0);

        // jal: 0,1,9,7,0
        exp_q = '{4'd0, 4'd1, 4'd9, 4'd7, 4'd0};
        run_seq("jal", 7'b1101111, 3'b000, 1'b0, 5);
        check_eq("jal_pcw2",   {31'd0, c_pcw[2]},  32'd1);
        check_eq("jal_srca2",  {30'd0, c_srca[2]}, 32'd1);
        check_eq("jal_srcb2",  {30'd0, c_srcb[2]}, 32'd2);
        check_eq("jal_regw3",  {31'd0, c_regw[3]}, 32'd1);
        check_eq("jal_immsrc", {30'd0, c_imm[1]},  32'd3);

        // beq taken: 0,1,10,0
        exp_q = '{4'd0, 4'd1, 4'd10, 4'd0};
        run_seq("beqt", 7'b1100011, 3'b000, 1'b1, 4);
        check_eq("beqt_aluop2", {30'd0, c_aluop[2]}, 32'd1);
        check_eq("beqt_pcw2",   {31'd0, c_pcw[2]},   32'd1);
        check_eq("beqt_pcw1",   {31'd0, c_pcw[1]},   32'd0);
        check_eq("beqt_immsrc", {30'd0, c_imm[1]},   32'd2);

        // beq not taken
        exp_q = '{4'd0, 4'd1, 4'd10, 4'd0};
        run_seq("beqn", 7'b1100011, 3'b000, 1'b0, 4);
        check_eq("beqn_pcw2", {31'd0, c_pcw[2]}, 32'd0);

        // funct3=001: bne when the feature is built in, plain beq otherwise
        exp_q = '{4'd0, 4'd1, 4'd10, 4'd0};
        run_seq("bnez0", 7'b1100011, 3'b001, 1'b0, 4);
`ifdef RISCV_MAINFSM_BNE_EN
        check_eq("bnez0_pcw2", {31'd0, c_pcw[2]}, 32'd1);
`else
        check_eq("bnez0_pcw2", {31'd0, c_pcw[2]}, 32'd0);
`endif
        exp_q = '{4'd0, 4'd1, 4'd10, 4'd0};
        run_seq("bnez1", 7'b1100011, 3'b001, 1'b1, 4);
`ifdef RISCV_MAINFSM_BNE_EN
        check_eq("bnez1_pcw2", {31'd0, c_pcw[2]}, 32'd0);
`else
        check_eq("bnez1_pcw2", {31'd0, c_pcw[2]}, 32'd1);
`endif

        // illegal opcode: 0,1,0 with a one-cycle pulse in DECODE
        exp_q = '{4'd0, 4'd1, 4'd0};
        run_seq("ill", 7'b1111111, 3'b000, 1'b1, 3);
        check_eq("ill_pulse0", {31'd0, c_ill[0]}, 32'd0);
        check_eq("ill_pulse1", {31'd0, c_ill[1]}, 32'd1);
        check_eq("ill_pulse2", {31'd0, c_ill[2]}, 32'd0);
        check_eq("ill_immsrc", {30'd0, c_imm[1]}, 32'd0);
        check_eq("ill_regw1",  {31'd0, c_regw[1]}, 32'd0);

        // a legal opcode never raises illegal_op in DECODE
        exp_q = '{4'd0, 4'd1, 4'd6, 4'd7, 4'd0};
        run_seq("rtype2", 7'b0110011, 3'b111, 1'b0, 5);
        check_eq("rtype2_ill1", {31'd0, c_ill[1]}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
